// File: rtl/cache_ctrl.sv
// Sequencing controller for one direct-mapped cache way: tag lookup, block fill on
// read miss, write-through on write, and flush/invalidate sequencing.
module cache_ctrl #(
  parameter  int LINES           = 2,
  parameter  int WORDS_PER_BLOCK = 32,
  localparam int OFF_W           = $clog2(WORDS_PER_BLOCK),
  localparam int IDX_W           = $clog2(LINES),
  localparam int TAG_LENGTH      = 32 - IDX_W - OFF_W - 2 + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           a,
  input  logic [31:0]           d,
  input  logic                  rd,
  input  logic                  we,
  output logic [31:0]           spo,
  output logic                  ready,
  input  logic                  flush,
  output logic                  busy,
  output logic [31:0]           mem_a,
  output logic [31:0]           mem_d,
  output logic                  mem_we,
  output logic                  mem_rd,
  input  logic [31:0]           mem_spo,
  input  logic                  mem_ready,
  output logic                  way_en,
  output logic [31:0]           way_a,
  output logic [31:0]           way_d,
  output logic                  way_we,
  output logic                  way_tag_we,
  output logic [TAG_LENGTH-1:0] way_tag_in,
  input  logic [TAG_LENGTH-1:0] way_tag_out,
  input  logic [31:0]           way_spo,
  output logic                  way_invalidate,
  input  logic                  way_init_done
);

  localparam int TAG_W = TAG_LENGTH - 1;

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP,
    S_HIT,
    S_FILL,
    S_TAGW,
    S_RESP,
    S_WMEM,
    S_WDONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_a;
  logic [31:0]       r_d;
  logic              r_we;
  logic [OFF_W-1:0]  r_k;
  logic [31:0]       r_resp;
  logic              r_flush_pend;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_W-1:0]  w_off;
  logic              w_hit;
  logic              w_flush_req;
  logic [31:0]       w_fill_a;

  assign w_tag       = r_a[31:IDX_W+OFF_W+2];
  assign w_idx       = r_a[IDX_W+OFF_W+1:OFF_W+2];
  assign w_off       = r_a[OFF_W+1:2];
  assign w_hit       = (way_tag_out == {1'b1, w_tag});
  assign w_flush_req = r_flush_pend | flush;
  assign w_fill_a    = {w_tag, w_idx, r_k, 2'b00};
  assign busy        = (r_state != S_IDLE);

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_next         = r_state;
    spo            = '0;
    ready          = 1'b0;
    mem_a          = '0;
    mem_d          = '0;
    mem_we         = 1'b0;
    mem_rd         = 1'b0;
    way_en         = 1'b0;
    way_a          = r_a;
    way_d          = r_d;
    way_we         = 1'b0;
    way_tag_we     = 1'b0;
    way_tag_in     = {1'b1, w_tag};
    way_invalidate = 1'b0;

    unique case (r_state)
      S_INIT: begin
        if (way_init_done) w_next = S_IDLE;
      end

      S_IDLE: begin
        if (w_flush_req) begin
          way_invalidate = 1'b1;
          w_next         = S_INIT;
        end else if (rd || we) begin
          w_next = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        way_en = 1'b1;
        if (r_we) begin
          way_we = w_hit;
          w_next = S_WMEM;
        end else begin
          w_next = w_hit ? S_HIT : S_FILL;
        end
      end

      S_HIT: begin
        spo    = way_spo;
        ready  = 1'b1;
        w_next = S_IDLE;
      end

      S_FILL: begin
        mem_rd = 1'b1;
        mem_a  = w_fill_a;
        if (mem_ready) begin
          way_en = 1'b1;
          way_we = 1'b1;
          way_a  = w_fill_a;
          way_d  = mem_spo;
          if (&r_k) w_next = S_TAGW;
        end
      end

      // Tag is written only after the whole block landed, so an abandoned fill stays invalid.
      S_TAGW: begin
        way_en     = 1'b1;
        way_tag_we = 1'b1;
        w_next     = S_RESP;
      end

      S_RESP: begin
        spo    = r_resp;
        ready  = 1'b1;
        w_next = S_IDLE;
      end

      S_WMEM: begin
        mem_we = 1'b1;
        mem_a  = r_a;
        mem_d  = r_d;
        if (mem_ready) w_next = S_WDONE;
      end

      S_WDONE: begin
        ready  = 1'b1;
        w_next = S_IDLE;
      end

      default: w_next = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_INIT;
      r_a          <= '0;
      r_d          <= '0;
      r_we         <= 1'b0;
      r_k          <= '0;
      r_resp       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state <= w_next;

      if (r_state == S_IDLE) begin
        if (w_flush_req) begin
          r_flush_pend <= 1'b0;
        end else if (rd || we) begin
          r_a  <= a;
          r_d  <= d;
          r_we <= we;
          r_k  <= '0;
        end
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end

      if (r_state == S_FILL && mem_ready) begin
        if (r_k == w_off) r_resp <= mem_spo;
        r_k <= r_k + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: behavioural way and main-memory models, with
// queues of expected CPU responses, memory transactions and tag writes.
module tb_cache_ctrl;

  localparam int TAG_LENGTH = 25;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [31:0]           a = '0;
  logic [31:0]           d = '0;
  logic                  rd = 1'b0;
  logic                  we = 1'b0;
  logic [31:0]           spo;
  logic                  ready;
  logic                  flush = 1'b0;
  logic                  busy;
  logic [31:0]           mem_a;
  logic [31:0]           mem_d;
  logic                  mem_we;
  logic                  mem_rd;
  logic [31:0]           mem_spo;
  logic                  mem_ready;
  logic                  way_en;
  logic [31:0]           way_a;
  logic [31:0]           way_d;
  logic                  way_we;
  logic                  way_tag_we;
  logic [TAG_LENGTH-1:0] way_tag_in;
  logic [TAG_LENGTH-1:0] way_tag_out;
  logic [31:0]           way_spo;
  logic                  way_invalidate;
  logic                  way_init_done;

  cache_ctrl #(.LINES(2), .WORDS_PER_BLOCK(32)) dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .rd(rd), .we(we), .spo(spo), .ready(ready),
    .flush(flush), .busy(busy), .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we),
    .mem_rd(mem_rd), .mem_spo(mem_spo), .mem_ready(mem_ready), .way_en(way_en),
    .way_a(way_a), .way_d(way_d), .way_we(way_we), .way_tag_we(way_tag_we),
    .way_tag_in(way_tag_in), .way_tag_out(way_tag_out), .way_spo(way_spo),
    .way_invalidate(way_invalidate), .way_init_done(way_init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] data;
    int          lat;
    int          t0;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_t;

  typedef struct {
    logic                  idx;
    logic [TAG_LENGTH-1:0] tag;
  } tag_t;

  resp_t exp_resp[$];
  mem_t  exp_mem[$];
  tag_t  exp_tag[$];

  int n_resp   = 0;
  int n_memr   = 0;
  int n_memw   = 0;
  int n_way_we = 0;
  int n_inv    = 0;
  int resp_mark = 0;

  // Way model: combinational tag read, registered data read, tag sweep of 4 cycles.
  logic [TAG_LENGTH-1:0] w_tags [2];
  logic [31:0]           w_data [2][32];
  int                    init_cnt;

  assign way_tag_out = w_tags[way_a[7]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      w_tags[0]     <= '0;
      w_tags[1]     <= '0;
      init_cnt      <= 4;
      way_init_done <= 1'b0;
      way_spo       <= '0;
    end else begin
      if (way_invalidate) begin
        w_tags[0]     <= '0;
        w_tags[1]     <= '0;
        init_cnt      <= 4;
        way_init_done <= 1'b0;
      end else if (init_cnt != 0) begin
        init_cnt <= init_cnt - 1;
        if (init_cnt == 1) way_init_done <= 1'b1;
      end
      if (way_en && way_tag_we) w_tags[way_a[7]] <= way_tag_in;
      if (way_en && way_we) w_data[way_a[7]][way_a[6:2]] <= way_d;
      if (way_en) way_spo <= w_data[way_a[7]][way_a[6:2]];
    end
  end

  // Memory model: answers each request with a one-cycle mem_ready three edges after accepting it.
  logic [31:0] mem_store [logic [31:0]];
  bit          m_busy;
  int          m_cnt;
  bit          m_we;
  logic [31:0] m_a;
  logic [31:0] m_d;
  mem_t        m_exp;

  function automatic logic [31:0] mem_value(input logic [31:0] addr);
    if (mem_store.exists(addr)) return mem_store[addr];
    return 32'h1000 + {27'd0, addr[6:2]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy    <= 1'b0;
      m_cnt     <= 0;
      mem_ready <= 1'b0;
      mem_spo   <= '0;
    end else if (mem_ready) begin
      mem_ready <= 1'b0;
      m_busy    <= 1'b0;
    end else if (!m_busy && (mem_rd || mem_we)) begin
      m_busy <= 1'b1;
      m_cnt  <= 1;
      m_we   <= mem_we;
      m_a    <= mem_a;
      m_d    <= mem_d;
      if (mem_we) n_memw++;
      else        n_memr++;
      if (exp_mem.size() == 0) begin
        check("mem_unexpected_req", mem_a, 32'hFFFF_FFFF);
      end else begin
        m_exp = exp_mem.pop_front();
        check("mem_op_we", {31'd0, mem_we}, {31'd0, m_exp.we});
        check("mem_addr", mem_a, m_exp.addr);
        if (m_exp.we) check("mem_wdata", mem_d, m_exp.data);
      end
    end else if (m_busy) begin
      check("mem_req_held", {31'd0, m_we ? mem_we : mem_rd}, 32'd1);
      check("mem_addr_stable", mem_a, m_a);
      if (m_cnt == 2) begin
        mem_ready <= 1'b1;
        if (m_we) mem_store[m_a] = m_d;
        mem_spo <= m_we ? 32'h0 : mem_value(m_a);
      end
      m_cnt <= m_cnt + 1;
    end
  end

  // Monitor: pops an expected response on every ready and checks side channels.
  bit    prev_ready = 1'b0;
  resp_t r_exp;
  tag_t  t_exp;

  always @(negedge clk) begin
    if (mem_rd && mem_we) check("mem_rd_we_exclusive", 32'd1, 32'd0);
    if (way_en && way_we) n_way_we++;
    if (way_invalidate) n_inv++;
    if (way_en && way_tag_we) begin
      if (exp_tag.size() == 0) begin
        check("tag_unexpected_write", {7'd0, way_tag_in}, 32'hFFFF_FFFF);
      end else begin
        t_exp = exp_tag.pop_front();
        check("tag_value", {7'd0, way_tag_in}, {7'd0, t_exp.tag});
        check("tag_index", {31'd0, way_a[7]}, {31'd0, t_exp.idx});
      end
    end
    if (ready) begin
      if (prev_ready) check("ready_back_to_back", 32'd1, 32'd0);
      if (exp_resp.size() == 0) begin
        check("ready_unexpected", spo, 32'hFFFF_FFFF);
      end else begin
        r_exp = exp_resp.pop_front();
        if (r_exp.is_wr) check("write_mem_done", n_memw, r_exp.data);
        else             check("read_spo", spo, r_exp.data);
        if (r_exp.lat >= 0) check("ready_latency", cyc - r_exp.t0, r_exp.lat);
      end
      n_resp++;
    end
    prev_ready = ready;
  end

  task automatic push_fill(input logic [31:0] addr, input logic [TAG_LENGTH-1:0] tag);
    logic [31:0] base;
    base = {addr[31:7], 7'd0};
    for (int i = 0; i < 32; i++) exp_mem.push_back(mem_t'{1'b0, base + 32'(4 * i), 32'h0});
    exp_tag.push_back(tag_t'{addr[7], tag});
  endtask

  task automatic start_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] expv, input int lat);
    @(posedge clk);
    #1;
    resp_mark = n_resp;
    exp_resp.push_back(resp_t'{wr, expv, lat, cyc});
    a  = addr;
    d  = wdata;
    rd = !wr;
    we = wr;
  endtask

  task automatic finish_op(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (n_resp != resp_mark) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rd = 1'b0;
    we = 1'b0;
  endtask

  task automatic cpu_op(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] expv, input int lat);
    start_op(wr, addr, wdata, expv, lat);
    finish_op(2000);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n0;
  int r0;
  bit hit10;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_way_inv", {31'd0, way_invalidate}, 32'd0);
    check("rst_spo", spo, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Read held during INIT: no ready until the sweep finishes, then a cold fill.
    push_fill(32'h100, 25'h100_0001);
    r0 = n_memr;
    start_op(1'b0, 32'h100, 32'h0, 32'h1000, -1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("init_busy", {31'd0, busy}, 32'd1);
      check("init_no_ready", {31'd0, ready}, 32'd0);
    end
    finish_op(2000);
    check("cold_fill_reads", n_memr - r0, 32);
    check("cold_fill_left", exp_mem.size(), 0);

    // Read hit right after the fill.
    r0 = n_memr;
    cpu_op(1'b0, 32'h104, 32'h0, 32'h1001, 2);
    check("hit_no_mem", n_memr - r0, 0);

    // Write hit: one way write, one memory write; then read back.
    n0 = n_way_we;
    exp_mem.push_back(mem_t'{1'b1, 32'h108, 32'hDEAD_BEEF});
    cpu_op(1'b1, 32'h108, 32'hDEAD_BEEF, n_memw + 1, -1);
    check("wr_hit_way_we", n_way_we - n0, 1);
    cpu_op(1'b0, 32'h108, 32'h0, 32'hDEAD_BEEF, 2);

    // Write miss to same index, other tag: memory only.
    n0 = n_way_we;
    exp_mem.push_back(mem_t'{1'b1, 32'h208, 32'h1234_5678});
    cpu_op(1'b1, 32'h208, 32'h1234_5678, n_memw + 1, -1);
    check("wr_miss_way_we", n_way_we - n0, 0);
    cpu_op(1'b0, 32'h100, 32'h0, 32'h1000, 2);

    // Flush during a fill: fill completes, then a single invalidate.
    push_fill(32'h200, 25'h100_0002);
    n0 = n_inv;
    start_op(1'b0, 32'h200, 32'h0, 32'h1000, -1);
    repeat (40) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_deferred", n_inv - n0, 0);
    finish_op(2000);
    @(posedge clk);
    wait_idle(100);
    check("flush_inv_pulses", n_inv - n0, 1);
    r0 = n_memr;
    push_fill(32'h100, 25'h100_0001);
    cpu_op(1'b0, 32'h104, 32'h0, 32'h1001, -1);
    check("post_flush_refill", n_memr - r0, 32);

    // Reset mid-fill at word 10.
    push_fill(32'h200, 25'h100_0002);
    r0 = n_memr;
    start_op(1'b0, 32'h200, 32'h0, 32'h1000, -1);
    hit10 = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (n_memr - r0 >= 11) begin
        hit10 = 1'b1;
        break;
      end
    end
    check("reached_word10", {31'd0, hit10}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("arst_way_we", {31'd0, way_we}, 32'd0);
    check("arst_tag_we", {31'd0, way_tag_we}, 32'd0);
    check("arst_ready", {31'd0, ready}, 32'd0);
    check("arst_mem_a", mem_a, 32'd0);
    check("arst_spo", spo, 32'd0);
    exp_mem.delete();
    exp_resp.delete();
    exp_tag.delete();
    rd = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_idle(100);
    r0 = n_memr;
    push_fill(32'h100, 25'h100_0001);
    cpu_op(1'b0, 32'h100, 32'h0, 32'h1000, -1);
    check("post_reset_miss", n_memr - r0, 32);
    check("queues_empty", exp_mem.size() + exp_resp.size() + exp_tag.size(), 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing controller for one direct-mapped cache way (BRAM data blocks plus a distributed-RAM tag array with a self-clearing init sweep).
- Sits between the CPU bus and the main memory bus.
- Performs the tag lookup, block fill on read miss, write-through on write, and flush/invalidate sequencing.
- Drives all way control signals; the way holds no policy.

Parameters:
- LINES, 2, number of cache lines; power of two, ≥2.
- WORDS_PER_BLOCK, 32, 32-bit words per line; power of two, ≥2.
- OFF_W, $clog2(WORDS_PER_BLOCK), word offset width (derived, do not override).
- IDX_W, $clog2(LINES), index width (derived).
- TAG_LENGTH, 32-IDX_W-OFF_W-2+1, stored tag width: {valid, a[31:IDX_W+OFF_W+2]} (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- a  in  32  CPU byte address, word aligned
- d  in  32  CPU write data
- rd  in  1  CPU read request, held until ready
- we  in  1  CPU write request, held until ready
- spo  out  32  CPU read data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- flush  in  1  invalidate-all request (pulse)
- busy  out  1  high when not in IDLE
- mem_a  out  32  memory address
- mem_d  out  32  memory write data
- mem_we  out  1  memory write, held until mem_ready
- mem_rd  out  1  memory read, held until mem_ready
- mem_spo  in  32  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion pulse
- way_en  out  1  way enable
- way_a  out  32  way address (offset/index fields used)
- way_d  out  32  way write data
- way_we  out  1  way data write
- way_tag_we  out  1  way tag write
- way_tag_in  out  TAG_LENGTH  tag to write
- way_tag_out  in  TAG_LENGTH  tag at way_a index (combinational)
- way_spo  in  32  way data, valid one cycle after way_a is presented
- way_invalidate  out  1  start way tag clear sweep
- way_init_done  in  1  way tag sweep complete

Behaviour:
- Reset (asynchronous): state=INIT. ready, mem_we, mem_rd, way_we, way_tag_we, way_invalidate are 0; spo, mem_a, mem_d and the internal address/data latches are 0; pending-flush flag is cleared.
- Reset mid-fill or mid-write abandons the transaction. The memory request drops immediately; the partially filled line is not tagged, so it stays invalid.
- INIT: wait for way_init_done=1, then go to IDLE. rd/we are ignored in INIT; busy=1.
- IDLE:
  - A pending flush has priority over rd/we: pulse way_invalidate for 1 cycle, go to INIT.
  - Otherwise, rd or we latches a, d and op (we wins if both are asserted) and goes to LOOKUP.
- LOOKUP: present the latched address with way_en=1. Hit = way_tag_out == {1'b1, latched tag}.
  - Read hit → HIT.
  - Read miss → FILL with counter k=0.
  - Write: if hit, assert way_we with latched d in this cycle (write-through update). Hit or miss, go to WMEM. No write-allocate.
- HIT: spo=way_spo, ready=1 for 1 cycle, back to IDLE. The read-hit handshake rule is: request sampled at edge N, ready high in cycle N+2.
- FILL:
  - mem_rd=1 with mem_a={latched tag, latched index, k, 2'b00}; hold until mem_ready.
  - On mem_ready: way_we=1, way_a=mem_a, way_d=mem_spo in the same cycle. If k equals the latched offset, capture mem_spo into the response register. Then increment k.
  - After the write of k=WORDS_PER_BLOCK-1: next cycle assert way_tag_we with {1'b1, latched tag} at the latched index, go to RESP.
  - k is OFF_W bits wide; the terminal condition is k all-ones, not a wrap.
- RESP: spo=captured word, ready=1 for 1 cycle, go to IDLE.
- WMEM: mem_we=1, mem_a=latched a, mem_d=latched d; hold until mem_ready. In the cycle after mem_ready, ready=1, go to IDLE.
- mem_rd and mem_we are never asserted together. mem_a and mem_d stay stable while a memory request is held.
- flush asserted in any state other than IDLE sets the pending flag; the flush is serviced at the next IDLE. The in-flight transaction always completes first.
- way_en=1 in LOOKUP, in FILL cycles where way_we=1, and during the tag write; 0 otherwise.
- ready is never high for two consecutive cycles. The CPU must deassert rd/we in the cycle after ready; a request still high at that point is treated as new.

Test Plan:
- Reset release with way_init_done rising 4 cycles later: busy=1 until then; a rd asserted meanwhile gets no ready; after IDLE the rd completes normally.
- Cold read a=0x100 (WORDS_PER_BLOCK=32, LINES=2), memory returns word i = 0x1000+i with mem_ready 3 cycles after each mem_rd: exactly 32 mem_rd transactions at 0x100..0x17C; the tag written is {1, 0x100 tag}; spo=0x1000 with ready pulse.
- Read 0x104 right after the fill: no mem_rd; ready 2 cycles after the request with spo=0x1001.
- Write 0x108 with d=0xDEADBEEF (hit): way_we in LOOKUP, then one mem_we at 0x108. A following read of 0x108 hits and returns 0xDEADBEEF. A write to 0x208 (miss, same index, other tag): mem_we only, no way_we, no tag change.
- flush pulsed during a fill: the fill completes and ready is pulsed. Then way_invalidate pulses once and state returns to INIT; the next read of 0x104 misses and refills.
- rst asserted mid-fill at word 10: all outputs go to 0 asynchronously. After re-init, a read of 0x100 misses (the line was never tagged).
